mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The module SHALL have no parameters; the data width SHALL be fixed at 32 bits.
REQ-002 The module SHALL use one clock; reset SHALL be synchronous and active-high, with ports named clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to accept one operation this cycle.
REQ-006 kill  input  1  pipeline flush; aborts any operation in flight.
REQ-007 funct3  input  3  RV32M operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 a  input  32  rs1 operand, taken from register-file read port a.
REQ-009 b  input  32  rs2 operand, taken from register-file read port b.
REQ-010 rd  input  5  destination register index.
REQ-011 busy  output  1  high while an operation is in flight; start is ignored while busy.
REQ-012 done  output  1  single-cycle pulse marking result valid.
REQ-013 d  output  32  result, feeding the register-file write data.
REQ-014 w  output  5  destination index of the completed operation.
REQ-015 wen  output  1  register-file write enable, equal to done AND (w != 0).

Function
REQ-016 The FSM SHALL have four states: IDLE, CALC, FIX and DONE.
REQ-017 IDLE->CALC SHALL occur when start=1 and kill=0; on that edge funct3, rd and the operand magnitudes plus sign flags SHALL be captured.
REQ-018 CALC SHALL run exactly 32 iterations, one bit per cycle: shift-add for multiply, restoring shift-subtract for divide, both on unsigned magnitudes with a 6-bit counter.
REQ-019 FIX SHALL last one cycle and apply sign correction and result selection: MUL = low 32 bits; MULH/MULHSU/MULHU = high 32 bits of the 64-bit product; DIV/DIVU = quotient; REM/REMU = remainder.
REQ-020 Signedness SHALL be as follows: MULH and DIV/REM treat both operands as signed; MULHSU treats a as signed and b as unsigned; the U variants treat both as unsigned.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle with d, w and wen valid; the FSM then SHALL return to IDLE.
REQ-022 Latency SHALL be fixed for all eight operations: done is high in the 34th cycle after the accepting edge; busy is high from the cycle after acceptance through the DONE cycle.
REQ-023 The earliest back-to-back start SHALL be accepted in the cycle after done.
REQ-024 Divide by zero: quotient SHALL be 0xFFFFFFFF and remainder SHALL be a, for both signed and unsigned; no exception.
REQ-025 Signed overflow (0x80000000 / 0xFFFFFFFF): quotient SHALL be 0x80000000 and remainder SHALL be 0.
REQ-026 Remainder sign SHALL follow the dividend, and quotient SHALL truncate toward zero.
REQ-027 Kill in any non-IDLE state SHALL force IDLE on the next edge with no done or wen pulse for the aborted operation.
REQ-028 Kill with start in IDLE: start SHALL be ignored.
REQ-029 d and w SHALL hold their last completed values until the next DONE.

Reset
REQ-030 Reset SHALL take priority over kill and start.
REQ-031 Reset SHALL force state=IDLE, busy=0, done=0, wen=0, d=0, w=0 and counter=0 on the next edge.
REQ-032 Reset mid-operation SHALL discard the operation with no done pulse.

Structure
REQ-033 A shared package riscv_pkg SHALL hold: the md_op_t enum for funct3 encodings, the mdu_state_t enum, and the constants XLEN=32 and MDU_ITERS=32.
REQ-034 The module SHALL be a single module with no sub-module; the datapath SHALL use one shared 64-bit accumulator/shift register for both multiply and divide.

Verification
REQ-035 MUL a=7, b=0xFFFFFFFD, rd=5 -> after 34 cycles, done=1, d=0xFFFFFFEB, w=5, wen=1.
REQ-036 MULH 0x80000000*0x80000000 -> d=0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> d=0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> d=0xFFFFFFFF.
REQ-037 DIV 0xFFFFFFF9/2 -> d=0xFFFFFFFD; REM of the same operands -> d=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> d=0x80000000; REM of the same operands -> d=0.
REQ-038 DIVU 5/0 -> d=0xFFFFFFFF; REMU 5/0 -> d=5; both with rd=0 -> done=1, wen=0.
REQ-039 start pulsed while busy -> ignored, and exactly one done is seen; kill at cycle 10 -> no done, busy=0 next cycle, and a new start is then accepted.
REQ-040 reset asserted at cycle 20 of an operation -> all outputs 0 next edge, no done ever for that operation.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32M encodings, multiply/divide FSM states and widths
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int MDU_ITERS = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } mdu_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit, fixed 34-cycle latency
module mul_div_unit
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] d,
    output logic [4:0]      w,
    output logic            wen
);

    mdu_state_t        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    md_op_t            op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic              b_zero_q, b_zero_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   d_q, d_d;
    logic [4:0]        w_q, w_d;

    logic              accept;
    logic              a_signed, b_signed;
    logic              sa, sb;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] mul_next, div_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, result;

    assign accept = (state_q == S_IDLE) && start && !kill;

    always_comb begin
        a_signed = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                   (funct3 == OP_DIV)  || (funct3 == OP_REM);
        b_signed = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
        sa       = a_signed && a[XLEN-1];
        sb       = b_signed && b[XLEN-1];
        a_mag    = sa ? (~a + 32'd1) : a;
        b_mag    = sb ? (~b + 32'd1) : b;
    end

    // Multiply: acc = {partial, multiplier}, add multiplicand into the top half then shift right.
    // Divide: acc = {remainder, dividend/quotient}, shift left and try subtracting the divisor.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
        div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    // Divide-by-zero leaves the dividend magnitude as remainder, so re-applying the
    // dividend sign yields a; only the quotient needs forcing to all ones.
    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? (~acc_q + 64'd1) : acc_q;
        quo  = acc_q[XLEN-1:0];
        rem  = acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                         result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                result = b_zero_q ? 32'hFFFF_FFFF :
                                                     ((neg_a_q ^ neg_b_q) ? (~quo + 32'd1) : quo);
            default:                        result = neg_a_q ? (~rem + 32'd1) : rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start && !kill) state_d = S_CALC;
            S_CALC: begin
                if (kill)
                    state_d = S_IDLE;
                else if (cnt_q == 6'(MDU_ITERS - 1))
                    state_d = S_FIX;
            end
            S_FIX:  state_d = kill ? S_IDLE : S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        b_zero_d = b_zero_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        d_d      = d_q;
        w_d      = w_q;
        if (accept) begin
            cnt_d    = 6'd0;
            op_d     = md_op_t'(funct3);
            rd_d     = rd;
            neg_a_d  = sa;
            neg_b_d  = sb;
            b_zero_d = (b == 32'd0);
            opnd_d   = funct3[2] ? b_mag : a_mag;
            acc_d    = funct3[2] ? {32'd0, a_mag} : {32'd0, b_mag};
        end else if (state_q == S_CALC && !kill) begin
            cnt_d = cnt_q + 6'd1;
            acc_d = op_q[2] ? div_next : mul_next;
        end else if (state_q == S_FIX && !kill) begin
            d_d = result;
            w_d = rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            op_q     <= OP_MUL;
            rd_q     <= 5'd0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            d_q      <= '0;
            w_q      <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            b_zero_q <= b_zero_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            d_q      <= d_d;
            w_q      <= w_d;
        end
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
        wen  = done && (w_q != 5'd0);
        d    = d_q;
        w    = w_q;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        busy;
    logic        done;
    logic [31:0] d;
    logic [4:0]  w;
    logic        wen;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .rd     (rd),
        .busy   (busy),
        .done   (done),
        .d      (d),
        .w      (w),
        .wen    (wen)
    );

    // Issues one operation and reports latency (cycles after the accepting edge) and outputs.
    task automatic do_op(input logic [2:0] f, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [4:0] r, output int lat, output logic [31:0] od,
                         output logic [4:0] ow, output logic owen, output logic obusy);
        @(negedge clk);
        start = 1'b1; funct3 = f; a = aa; b = bb; rd = r;
        lat = -1; od = '0; ow = '0; owen = 1'b0; obusy = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) obusy = busy;
            if (done === 1'b1) begin
                lat = c; od = d; ow = w; owen = wen;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'b0; a = '0; b = '0; rd = '0;
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++; if (wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %b want 0", wen); end
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_d got %h want 0", d); end
        n_tests++; if (w !== 5'd0) begin n_fail++; $display("FAIL reset_w got %0d want 0", w); end
        reset = 1'b0;
    endtask

    task automatic test_mul;
        int lat; logic [31:0] od; logic [4:0] ow; logic owen, ob;
        do_op(F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, lat, od, ow, owen, ob);
        n_tests++; if (ob !== 1'b1) begin n_fail++; $display("FAIL mul_busy got %b want 1", ob); end
        n_tests++; if (lat != 34) begin n_fail++; $display("FAIL mul_latency got %0d want 34", lat); end
        n_tests++; if (od !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_d got %h want ffffffeb", od); end
        n_tests++; if (ow !== 5'd5) begin n_fail++; $display("FAIL mul_w got %0d want 5", ow); end
        n_tests++; if (owen !== 1'b1) begin n_fail++; $display("FAIL mul_wen got %b want 1", owen); end
        @(negedge clk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse got %b want 0", done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_after got %b want 0", busy); end
        n_tests++; if (d !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_d_hold got %h want ffffffeb", d); end
    endtask

    task automatic test_mul_high;
        int lat; logic [31:0] od; logic [4:0] ow; logic owen, ob;
        do_op(F_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1, lat, od, ow, owen, ob);
        n_tests++; if (od !== 32'h4000_0000) begin n_fail++; $display("FAIL mulh_d got %h want 40000000", od); end
        do_op(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, lat, od, ow, owen, ob);
        n_tests++; if (od !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_d got %h want fffffffe", od); end
        do_op(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, lat, od, ow, owen, ob);
        n_tests++; if (od !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu_d got %h want ffffffff", od); end
        n_tests++; if (lat != 34) begin n_fail++; $display("FAIL mulhsu_latency got %0d want 34", lat); end
        do_op(F_MUL, 32'd12345, 32'd1000, 5'd4, lat, od, ow, owen, ob);
        n_tests++; if (od !== 32'd12345000) begin n_fail++; $display("FAIL mul_pos_d got %h want %h", od, 32'd12345000); end
    endtask

    task automatic test_div;
        int lat; logic [31:0] od; logic [4:0] ow; logic owen, ob;
        do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6, lat, od, ow, owen, ob);
        n_tests++; if (od !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_d got %h want fffffffd", od); end
        n_tests++; if (lat != 34) begin n_fail++; $display("FAIL div_latency got %0d want 34", lat); end
        do_op(F_REM, 32'hFFFF_FFF9, 32'd2, 5'd7, lat, od, ow, owen, ob);
        n_tests++; if (od !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_neg_d got %h want ffffffff", od); end
        do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, lat, od, ow, owen, ob);
        n_tests++; if (od !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_d got %h want 80000000", od); end
        do_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, lat, od, ow, owen, ob);
        n_tests++; if (od !== 32'd0) begin n_fail++; $display("FAIL rem_ovf_d got %h want 0", od); end
        do_op(F_DIVU, 32'd100, 32'd7, 5'd10, lat, od, ow, owen, ob);
        n_tests++; if (od !== 32'd14) begin n_fail++; $display("FAIL divu_d got %h want e", od); end
        do_op(F_REMU, 32'd100, 32'd7, 5'd11, lat, od, ow, owen, ob);
        n_tests++; if (od !== 32'd2) begin n_fail++; $display("FAIL remu_d got %h want 2", od); end
        do_op(F_REM, 32'd7, 32'hFFFF_FFFE, 5'd12, lat, od, ow, owen, ob);
        n_tests++; if (od !== 32'd1) begin n_fail++; $display("FAIL rem_pos_neg_d got %h want 1", od); end
    endtask

    task automatic test_div_zero;
        int lat; logic [31:0] od; logic [4:0] ow; logic owen, ob;
        do_op(F_DIVU, 32'd5, 32'd0, 5'd0, lat, od, ow, owen, ob);
        n_tests++; if (lat != 34) begin n_fail++; $display("FAIL divu0_done got latency %0d want 34", lat); end
        n_tests++; if (od !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_d got %h want ffffffff", od); end
        n_tests++; if (owen !== 1'b0) begin n_fail++; $display("FAIL divu0_wen got %b want 0", owen); end
        do_op(F_REMU, 32'd5, 32'd0, 5'd0, lat, od, ow, owen, ob);
        n_tests++; if (od !== 32'd5) begin n_fail++; $display("FAIL remu0_d got %h want 5", od); end
        n_tests++; if (owen !== 1'b0) begin n_fail++; $display("FAIL remu0_wen got %b want 0", owen); end
        do_op(F_DIV, 32'hFFFF_FFF9, 32'd0, 5'd13, lat, od, ow, owen, ob);
        n_tests++; if (od !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_d got %h want ffffffff", od); end
        do_op(F_REM, 32'hFFFF_FFF9, 32'd0, 5'd14, lat, od, ow, owen, ob);
        n_tests++; if (od !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL rem0_d got %h want fffffff9", od); end
    endtask

    task automatic test_busy_ignore;
        int dones = 0; logic [31:0] first_d = '0;
        @(negedge clk);
        start = 1'b1; funct3 = F_MUL; a = 32'd3; b = 32'd4; rd = 5'd3;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 5) begin start = 1'b1; funct3 = F_DIVU; a = 32'd100; b = 32'd7; end
            if (done === 1'b1) begin
                if (dones == 0) first_d = d;
                dones++;
            end
        end
        n_tests++; if (dones != 1) begin n_fail++; $display("FAIL busy_ignore_dones got %0d want 1", dones); end
        n_tests++; if (first_d !== 32'd12) begin n_fail++; $display("FAIL busy_ignore_d got %h want c", first_d); end
    endtask

    task automatic test_kill;
        int dones = 0; int lat; logic [31:0] od; logic [4:0] ow; logic owen, ob;
        @(negedge clk);
        start = 1'b1; funct3 = F_DIV; a = 32'd50; b = 32'd5; rd = 5'd15;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 10) kill = 1'b1;
            if (c == 11) begin
                kill = 1'b0;
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy got %b want 0", busy); end
            end
            if (done === 1'b1) dones++;
        end
        n_tests++; if (dones != 0) begin n_fail++; $display("FAIL kill_no_done got %0d dones want 0", dones); end
        do_op(F_MUL, 32'd6, 32'd7, 5'd16, lat, od, ow, owen, ob);
        n_tests++; if (lat != 34) begin n_fail++; $display("FAIL kill_restart_latency got %0d want 34", lat); end
        n_tests++; if (od !== 32'd42) begin n_fail++; $display("FAIL kill_restart_d got %h want 2a", od); end
    endtask

    task automatic test_kill_start;
        @(negedge clk);
        start = 1'b1; kill = 1'b1; funct3 = F_MUL; a = 32'd1; b = 32'd1; rd = 5'd1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_start_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] od; logic [4:0] ow; logic owen, ob;
        do_op(F_MULHU, 32'h0001_0000, 32'h0001_0000, 5'd17, lat, od, ow, owen, ob);
        n_tests++; if (od !== 32'd1) begin n_fail++; $display("FAIL b2b_first_d got %h want 1", od); end
        do_op(F_DIVU, 32'hFFFF_FFFF, 32'h10, 5'd18, lat, od, ow, owen, ob);
        n_tests++; if (ob !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy %b want 1", ob); end
        n_tests++; if (lat != 34) begin n_fail++; $display("FAIL b2b_latency got %0d want 34", lat); end
        n_tests++; if (od !== 32'h0FFF_FFFF) begin n_fail++; $display("FAIL b2b_second_d got %h want 0fffffff", od); end
        n_tests++; if (ow !== 5'd18) begin n_fail++; $display("FAIL b2b_w got %0d want 18", ow); end
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        @(negedge clk);
        start = 1'b1; funct3 = F_REM; a = 32'd77; b = 32'd10; rd = 5'd20;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 20) reset = 1'b1;
            if (c == 21) begin
                reset = 1'b0;
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
                n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL rstmid_d got %h want 0", d); end
                n_tests++; if (w !== 5'd0) begin n_fail++; $display("FAIL rstmid_w got %0d want 0", w); end
                n_tests++; if (wen !== 1'b0) begin n_fail++; $display("FAIL rstmid_wen got %b want 0", wen); end
            end
            if (done === 1'b1) dones++;
        end
        n_tests++; if (dones != 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d dones want 0", dones); end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_mul_high;
        test_div;
        test_div_zero;
        test_busy_ignore;
        test_kill;
        test_kill_start;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
